// File: rtl/mem_port_ctrl.sv
// -----------------------------------------------------------------------------
// mem_port_ctrl
//
// Sequential initiator for one port of the 16-bit, byte-addressed dual-port
// data memory. Turns single load/store requests from the core into properly
// sequenced address / data / write-enable activity on the memory port.
//
// The memory always writes two bytes (addr, addr+1) and its write-enable is
// edge- and address-sensitive. This block therefore:
//   - holds mem_addr/mem_wdata stable for SETUP_CYCLES cycles before mem_we rises,
//   - pulses mem_we for exactly one cycle,
//   - holds address and data for one more cycle after mem_we falls.
// Byte stores use read-modify-write so that the byte at addr+1 is rewritten
// with its current value.
//
// Optional feature macro: MEMCTL_BYTE_RMW_EN
//   defined   : byte loads and read-modify-write byte stores.
//   undefined : req_byte is ignored and every access is a 16-bit word access.
//
// Parameters
//   SETUP_CYCLES  address/data setup cycles before mem_we rises (1..7)
//
// Ports
//   clk        in   system clock, rising edge
//   rstz       in   asynchronous active-low reset
//   req_valid  in   request present
//   req_ready  out  request accepted this cycle (registered)
//   req_we     in   1 = store, 0 = load
//   req_byte   in   1 = byte access, 0 = word access
//   req_addr   in   byte address (word is big-endian {mem[a], mem[a+1]})
//   req_wdata  in   store data (byte store uses [7:0])
//   rsp_valid  out  response present
//   rsp_ready  in   consumer takes the response
//   rsp_rdata  out  load data, 16'h0000 for stores
//   mem_addr   out  memory address
//   mem_wdata  out  memory write data
//   mem_we     out  memory write-enable
//   mem_rdata  in   memory read data (combinational from mem_addr)
//   dvdd/dgnd  io   supply pins, no logic
// -----------------------------------------------------------------------------
module mem_port_ctrl #(
    parameter int unsigned SETUP_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rstz,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic        req_byte,
    input  logic [15:0] req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [15:0] rsp_rdata,
    output logic [15:0] mem_addr,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    input  logic [15:0] mem_rdata,
    inout  wire         dvdd,
    inout  wire         dgnd
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_SETUP = 3'd2,
        ST_WR    = 3'd3,
        ST_HOLD  = 3'd4,
        ST_RESP  = 3'd5
    } state_e;

    // Counter reload value: SETUP lasts SETUP_CYCLES cycles, counting down to 0.
    localparam logic [2:0] SETUP_LAST = 3'(SETUP_CYCLES - 1);

    state_e      state_q, state_d;
    logic        we_q, we_d;
    logic [2:0]  cnt_q, cnt_d;
    logic [15:0] cap_q, cap_d;
    logic [15:0] mem_addr_q, mem_addr_d;
    logic [15:0] mem_wdata_q, mem_wdata_d;
    logic        mem_we_q, mem_we_d;
    logic        req_ready_q, req_ready_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [15:0] rsp_rdata_q, rsp_rdata_d;

    logic        accept_s;
    logic        acc_byte_s;
    logic        is_byte_s;
    logic [15:0] merge_s;

    // Supply pins are pass-through only; folding them here keeps them visibly consumed.
    logic unused_supply_s;
    assign unused_supply_s = dvdd ^ dgnd;

    assign accept_s = req_valid & req_ready_q;

`ifdef MEMCTL_BYTE_RMW_EN
    logic       byte_q, byte_d;
    logic [7:0] wbyte_q, wbyte_d;

    // Latch byte-access attributes of the accepted request.
    always_comb begin
        byte_d  = byte_q;
        wbyte_d = wbyte_q;
        if (accept_s) begin
            byte_d  = req_byte;
            wbyte_d = req_wdata[7:0];
        end else begin
            byte_d  = byte_q;
            wbyte_d = wbyte_q;
        end
    end

    // Byte-attribute registers.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            byte_q  <= 1'b0;
            wbyte_q <= 8'h00;
        end else begin
            byte_q  <= byte_d;
            wbyte_q <= wbyte_d;
        end
    end

    assign acc_byte_s = req_byte;
    assign is_byte_s  = byte_q;
    // New byte goes to addr; addr+1 gets back exactly what was just read there.
    assign merge_s    = {wbyte_q, mem_rdata[7:0]};
`else
    logic unused_byte_s;
    assign unused_byte_s = req_byte;
    assign acc_byte_s    = 1'b0;
    assign is_byte_s     = 1'b0;
    assign merge_s       = mem_wdata_q;
`endif

    // Next-state and next-output logic for the access sequencer.
    always_comb begin
        state_d     = state_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        cap_d       = cap_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;

        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    we_d       = req_we;
                    mem_addr_d = req_addr;
                    if (req_we && !acc_byte_s) begin
                        mem_wdata_d = req_wdata;
                        cnt_d       = SETUP_LAST;
                        state_d     = ST_SETUP;
                    end else begin
                        // Loads and byte stores both read first.
                        state_d = ST_RD;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                cap_d = mem_rdata;
                if (we_q) begin
                    mem_wdata_d = merge_s;
                    cnt_d       = SETUP_LAST;
                    state_d     = ST_SETUP;
                end else begin
                    state_d = ST_RESP;
                end
            end
            ST_SETUP: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_WR;
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_WR: begin
                state_d = ST_HOLD;
            end
            ST_HOLD: begin
                state_d = ST_RESP;
            end
            ST_RESP: begin
                // First RESP cycle formats and registers the response.
                if (!rsp_valid_q) begin
                    rsp_valid_d = 1'b1;
                    if (we_q) begin
                        rsp_rdata_d = 16'h0000;
                    end else if (is_byte_s) begin
                        rsp_rdata_d = {8'h00, cap_q[15:8]};
                    end else begin
                        rsp_rdata_d = cap_q;
                    end
                end else if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end else begin
                    rsp_valid_d = 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Registered strobes follow the state being entered.
        req_ready_d = (state_d == ST_IDLE);
        mem_we_d    = (state_d == ST_WR);
    end

    // State and registered outputs; async clear drops mem_we immediately.
    always_ff @(posedge clk or negedge rstz) begin
        if (!rstz) begin
            state_q     <= ST_IDLE;
            we_q        <= 1'b0;
            cnt_q       <= 3'd0;
            cap_q       <= 16'h0000;
            mem_addr_q  <= 16'h0000;
            mem_wdata_q <= 16'h0000;
            mem_we_q    <= 1'b0;
            req_ready_q <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            cap_q       <= cap_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_we_q    <= mem_we_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign req_ready = req_ready_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_we    = mem_we_q;

endmodule

// File: tb/tb_mem_port_ctrl.sv
module tb_mem_port_ctrl;

    localparam int SETUP = 2;
`ifdef MEMCTL_BYTE_RMW_EN
    localparam bit BYTE_EN = 1'b1;
`else
    localparam bit BYTE_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rstz;
    logic        req_valid, req_ready, req_we, req_byte;
    logic [15:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready;
    logic [15:0] rsp_rdata, mem_addr, mem_wdata, mem_rdata;
    logic        mem_we;
    wire         dvdd;
    wire         dgnd;

    assign dvdd = 1'b1;
    assign dgnd = 1'b0;

    always #5 clk = ~clk;

    mem_port_ctrl #(.SETUP_CYCLES(SETUP)) dut (
        .clk(clk), .rstz(rstz),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_byte(req_byte), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
        .mem_rdata(mem_rdata), .dvdd(dvdd), .dgnd(dgnd)
    );

    // Memory: two bytes per write, committed on the rising edge of write-enable,
    // 16-bit address wrap for addr+1.
    logic [7:0]  tb_mem [0:65535];
    logic [15:0] mem_addr_p1;
    assign mem_addr_p1 = mem_addr + 16'd1;
    assign mem_rdata   = {tb_mem[mem_addr], tb_mem[mem_addr_p1]};

    initial begin
        for (int i = 0; i < 65536; i++) tb_mem[i] = 8'h00;
        forever begin
            @(posedge mem_we);
            tb_mem[mem_addr]    = mem_wdata[15:8];
            tb_mem[mem_addr_p1] = mem_wdata[7:0];
        end
    end

    // Reference: what the memory should contain, by the architectural rules.
    logic [7:0] ref_mem [0:65535];

    function automatic logic [15:0] ref_load(input logic bt, input logic [15:0] a);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (bt && BYTE_EN) return {8'h00, ref_mem[a]};
        else return {ref_mem[a], ref_mem[a1]};
    endfunction

    task automatic ref_store(input logic bt, input logic [15:0] a, input logic [15:0] wd);
        logic [15:0] a1;
        a1 = a + 16'd1;
        if (bt && BYTE_EN) begin
            ref_mem[a] = wd[7:0];
        end else begin
            ref_mem[a]  = wd[15:8];
            ref_mem[a1] = wd[7:0];
        end
    endtask

    function automatic int ref_lat(input logic we, input logic bt);
        if (!we) return 2;
        else if (bt && BYTE_EN) return 4 + SETUP;
        else return 3 + SETUP;
    endfunction

    int errs = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Issue one request (called at a negedge) and observe it to completion.
    task automatic do_req(input logic we, input logic bt, input logic [15:0] a, input logic [15:0] wd,
                          input int stall, output logic [15:0] rd, output int lat, output int pulses,
                          output logic addr_ok, output logic hs_ok, output logic to);
        int n;
        int k;
        rd = 16'h0000; lat = -1; pulses = 0; addr_ok = 1'b1; hs_ok = 1'b1; to = 1'b0;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            to = 1'b1;
            return;
        end
        req_valid = 1'b1; req_we = we; req_byte = bt; req_addr = a; req_wdata = wd;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 40) begin
            if (mem_we) pulses++;
            if (mem_addr !== a) addr_ok = 1'b0;
            if (k > 0 && req_ready) hs_ok = 1'b0;
            @(negedge clk);
            k++;
        end
        if (!rsp_valid) begin
            to = 1'b1;
            return;
        end
        lat = k;
        rd  = rsp_rdata;
        for (int s = 0; s < stall; s++) begin
            @(negedge clk);
            if (!rsp_valid || rsp_rdata !== rd || req_ready || mem_we) hs_ok = 1'b0;
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        if (rsp_valid || !req_ready) hs_ok = 1'b0;
    endtask

    task automatic run(input string tag, input logic we, input logic bt, input logic [15:0] a,
                       input logic [15:0] wd, input int stall, input logic [15:0] exp_rd, input int exp_lat);
        logic [15:0] rd;
        int lat, pulses;
        logic addr_ok, hs_ok, to;
        do_req(we, bt, a, wd, stall, rd, lat, pulses, addr_ok, hs_ok, to);
        check({tag, " timeout"}, 32'(to), 32'd0);
        check({tag, " rdata"}, 32'(rd), 32'(exp_rd));
        check({tag, " latency"}, 32'(lat), 32'(exp_lat));
        check({tag, " we_pulses"}, 32'(pulses), we ? 32'd1 : 32'd0);
        check({tag, " addr_stable"}, 32'(addr_ok), 32'd1);
        check({tag, " handshake"}, 32'(hs_ok), 32'd1);
    endtask

    typedef struct {
        logic        we;
        logic        bt;
        logic [15:0] addr;
        logic [15:0] wd;
        int          stall;
        logic [15:0] exp_rd;
        int          exp_lat;
    } vec_t;

    vec_t vt[9];

    initial begin
        logic        flag;
        int          n;
        logic        we, bt;
        logic [15:0] a, wd, erd;

        for (int i = 0; i < 65536; i++) ref_mem[i] = 8'h00;

        vt[0] = '{1'b1, 1'b0, 16'h0010, 16'hABCD, 0, 16'h0000, 3 + SETUP};
        vt[1] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 0, 16'hABCD, 2};
        vt[2] = '{1'b1, 1'b1, 16'h0010, 16'hE75A, 0, 16'h0000, BYTE_EN ? 4 + SETUP : 3 + SETUP};
        vt[3] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 0, BYTE_EN ? 16'h5ACD : 16'hE75A, 2};
        vt[4] = '{1'b0, 1'b1, 16'h0011, 16'h0000, 0, BYTE_EN ? 16'h00CD : 16'h5A00, 2};
        vt[5] = '{1'b1, 1'b0, 16'hFFFF, 16'h1234, 0, 16'h0000, 3 + SETUP};
        vt[6] = '{1'b0, 1'b1, 16'h0000, 16'h0000, 0, BYTE_EN ? 16'h0034 : 16'h3400, 2};
        vt[7] = '{1'b0, 1'b0, 16'hFFFF, 16'h0000, 0, 16'h1234, 2};
        vt[8] = '{1'b0, 1'b0, 16'h0010, 16'h0000, 5, BYTE_EN ? 16'h5ACD : 16'hE75A, 2};

        // Reset with a request pending: everything must stay quiet.
        rstz = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0;
        req_addr = 16'hFFFF; req_wdata = 16'hFFFF; rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("reset req_ready", 32'(req_ready), 32'd0);
        check("reset rsp_valid", 32'(rsp_valid), 32'd0);
        check("reset rsp_rdata", 32'(rsp_rdata), 32'd0);
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_wdata", 32'(mem_wdata), 32'd0);
        check("reset mem_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0; rsp_ready = 1'b0;
        rstz = 1'b1;
        #1;
        check("release req_ready before edge", 32'(req_ready), 32'd0);
        @(negedge clk);
        check("release req_ready after edge", 32'(req_ready), 32'd1);

        // Directed table.
        for (int i = 0; i < 9; i++) begin
            run($sformatf("vec%0d", i), vt[i].we, vt[i].bt, vt[i].addr, vt[i].wd,
                vt[i].stall, vt[i].exp_rd, vt[i].exp_lat);
            if (vt[i].we) ref_store(vt[i].bt, vt[i].addr, vt[i].wd);
        end

        // Reset pulsed while write-enable is high.
        req_valid = 1'b1; req_we = 1'b1; req_byte = 1'b0; req_addr = 16'h0040; req_wdata = 16'h9999;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        n = 0;
        while (!mem_we && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstwr reached WR", 32'(mem_we), 32'd1);
        #2 rstz = 1'b0;
        #1;
        check("rstwr mem_we async low", 32'(mem_we), 32'd0);
        check("rstwr req_ready low", 32'(req_ready), 32'd0);
        @(negedge clk);
        rstz = 1'b1;
        flag = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid || mem_we) flag = 1'b1;
        end
        check("rstwr no response", 32'(flag), 32'd0);
        check("rstwr back to idle", 32'(req_ready), 32'd1);
        // The memory saw the rising edge of write-enable before the reset hit.
        ref_store(1'b0, 16'h0040, 16'h9999);
        run("rstwr readback", 1'b0, 1'b0, 16'h0040, 16'h0000, 0, ref_load(1'b0, 16'h0040), 2);

        // Randomized traffic against the reference.
        for (int t = 0; t < 200; t++) begin
            we = 1'($urandom_range(0, 1));
            bt = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 1) == 0) a = 16'($urandom_range(0, 31));
            else a = 16'hFFF0 + 16'($urandom_range(0, 15));
            wd  = 16'($urandom);
            erd = we ? 16'h0000 : ref_load(bt, a);
            run($sformatf("rand%0d", t), we, bt, a, wd, $urandom_range(0, 3), erd, ref_lat(we, bt));
            if (we) ref_store(bt, a, wd);
        end

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/mem_port_ctrl.md
# mem_port_ctrl

Sequential initiator for one port of the 16-bit byte-addressed dual-port data memory: turns load/store requests from the core into correctly sequenced address/data/write-enable activity on that port. The memory's write-enable is edge- and address-sensitive and always writes two bytes (addr, addr+1), so this block provides setup/hold sequencing and read-modify-write for byte stores. One instance drives port A; a second instance drives port B.

## Interface
- SETUP_CYCLES, 1: cycles mem_addr/mem_wdata are held stable with mem_we=0 before mem_we rises (1..7).
- clk  in  1  system clock, all state on rising edge.
- rstz  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block accepts a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_byte  in  1  1 = byte access, 0 = 16-bit word access.
- req_addr  in  16  byte address; word = {mem[addr], mem[addr+1]} (big-endian).
- req_wdata  in  16  store data; byte store uses [7:0].
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer takes the response.
- rsp_rdata  out  16  load data; 16'h0000 for stores.
- mem_addr  out  16  to memory addressX.
- mem_wdata  out  16  to memory dataInX.
- mem_we  out  1  to memory writeEnableX.
- mem_rdata  in  16  from memory dataOutX (combinational).
- dvdd, dgnd  inout  1  supply pins, pass-through, no logic.

## Operation
- States: IDLE, RD, SETUP, WR, HOLD, RESP.
- IDLE: req_ready=1; on req_valid&req_ready latch we/byte/addr/wdata. Load -> RD; word store -> SETUP; byte store -> RD.
- RD: mem_addr=addr, mem_we=0, one cycle; capture mem_rdata at end of cycle. Load -> RESP; byte store -> SETUP.
- Load data: word -> mem_rdata; byte -> {8'h00, mem_rdata[15:8]}.
- Byte store merge: mem_wdata = {req_wdata[7:0], captured[7:0]} so byte at addr+1 is rewritten unchanged.
- SETUP: addr/wdata driven, mem_we=0, SETUP_CYCLES cycles -> WR.
- WR: mem_we=1 one cycle, addr/wdata unchanged -> HOLD.
- HOLD: mem_we=0, addr/wdata unchanged one cycle -> RESP. mem_addr never changes while mem_we=1.
- RESP: rsp_valid=1, rsp_rdata stable until rsp_ready; on rsp_valid&rsp_ready -> IDLE.
- Address 16'hFFFF: memory pairs it with 16'h0000; controller applies no special handling, no alignment restriction.
- Outside RD/SETUP/WR/HOLD mem_addr and mem_wdata hold last values; mem_we=0.

## Timing
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_wdata=0, mem_we=0, state=IDLE. req_ready registered, 1 from first rising edge after rstz release.
- rstz low mid-operation forces mem_we=0 immediately (async); a store interrupted in WR may be partially applied; no response issued.
- Accept at edge 0 (SETUP_CYCLES=1): load rsp_valid at edge 2; word store at edge 4; byte store at edge 5. Each extra SETUP cycle adds 1 to stores.
- Single outstanding request; req_ready=0 from accept until RESP handshake; next accept earliest one cycle after RESP handshake.
- rsp_ready held low stalls indefinitely in RESP; no outputs change.

## Configuration
- MEMCTL_BYTE_RMW_EN defined: byte loads/stores as above.
- Undefined: req_byte ignored, every access is a word access; byte store path and RD step for stores removed.

## Test plan
- Reset: rstz low with req_valid=1 -> all outputs 0; req_ready=1 one edge after release.
- Word store 16'hABCD to 16'h0010, then word load 16'h0010 -> rsp_rdata=16'hABCD at edge 2 after accept; mem_we exactly one cycle high, mem_addr stable from SETUP through HOLD.
- Byte store 8'h5A to 16'h0010 after above, word load -> 16'h5ACD; byte load 16'h0011 -> 16'h00CD (macro undefined: word store semantics, load returns 16'h005A... i.e. full req_wdata).
- Wrap: word store 16'h1234 to 16'hFFFF -> byte load 16'h0000 returns 16'h0034.
- Back-pressure: rsp_ready=0 for 5 cycles -> rsp_valid and rsp_rdata stable, req_ready=0, mem_we=0.
- rstz pulsed during WR -> mem_we falls asynchronously, rsp_valid never asserts, block returns to IDLE.
